// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle between control and the shift sequencer
interface shift_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int NW    = 5
);
   logic             start;
   logic [2:0]       op;
   logic [NW-1:0]    n;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] data_out;

   modport master (output start, op, n, data_in, input busy, done, data_out);
   modport slave  (input start, op, n, data_in, output busy, done, data_out);
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative one-bit-per-clock shifter with start/busy/done handshake
module shift_sequencer #(
   parameter int WIDTH = 32,
   parameter int NW    = 5
) (
   input  logic               clk,
   input  logic               reset,
   shift_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_ROL  = 3'b110;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [NW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] step;
   logic             op_valid;

   always_comb begin
      step = data_q;
      case (op_q)
         OP_SLL:  step = {data_q[WIDTH-2:0], 1'b0};
         OP_SRL:  step = {1'b0, data_q[WIDTH-1:1]};
         OP_SRA:  step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
         OP_ROR:  step = {data_q[0], data_q[WIDTH-1:1]};
         OP_ROL:  step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
         default: step = data_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      op_valid = (bus.op != 3'b000) && (bus.op != 3'b111);
      case (state_q)
         S_IDLE: begin
            if (bus.start && op_valid) begin
               data_d  = bus.data_in;
               cnt_d   = bus.n;
               op_d    = bus.op;
               // LOAD and a zero amount need no shift cycles at all
               state_d = (bus.op == OP_LOAD || bus.n == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            data_d = step;
            cnt_d  = cnt_q - NW'(1);
            if (cnt_q == NW'(1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE);
   assign bus.data_out = data_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized bench for shift_sequencer against an arithmetic model
module tb_shift_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   shift_sequencer_if #(.WIDTH(32), .NW(5)) sif ();

   shift_sequencer #(.WIDTH(32), .NW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Result after k single-bit steps, written as whole-word arithmetic
   function automatic logic [31:0] f(input logic [31:0] d, input logic [2:0] o, input int k);
      case (o)
         3'b010:  return d << k;
         3'b011:  return d >> k;
         3'b100:  return 32'($signed(d) >>> k);
         3'b101:  return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
         3'b110:  return (k == 0) ? d : ((d << k) | (d >> (32 - k)));
         default: return d;
      endcase
   endfunction

   int          m_phase, m_k, m_total;
   logic [31:0] m_orig;
   logic [2:0]  m_op;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= 0; m_k <= 0; m_total <= 0; m_orig <= '0; m_op <= 3'b001;
      end else begin
         case (m_phase)
            0: if (sif.start && sif.op != 3'b000 && sif.op != 3'b111) begin
                  m_orig  <= sif.data_in;
                  m_op    <= sif.op;
                  m_k     <= 0;
                  m_total <= (sif.op == 3'b001) ? 0 : int'(sif.n);
                  m_phase <= (sif.op == 3'b001 || sif.n == 5'd0) ? 2 : 1;
               end
            1: begin
                  m_k <= m_k + 1;
                  if (m_k + 1 == m_total) m_phase <= 2;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("busy", {31'd0, sif.busy}, {31'd0, m_phase != 0});
         chk("done", {31'd0, sif.done}, {31'd0, m_phase == 2});
         chk("data_out", sif.data_out, f(m_orig, m_op, m_k));
      end
   end

   task automatic req(input logic [2:0] o, input logic [4:0] nn, input logic [31:0] d,
                      input bit noise, output logic [31:0] res, output int lat, output int busy_cnt);
      bit got;
      @(negedge clk);
      sif.start = 1'b1; sif.op = o; sif.n = nn; sif.data_in = d;
      @(posedge clk); #1;
      sif.start = 1'b0; sif.op = 3'($urandom); sif.n = 5'($urandom); sif.data_in = $urandom;
      lat = 0; busy_cnt = 0; got = 1'b0; res = '0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (sif.busy) busy_cnt++;
         if (sif.done) begin
            res = sif.data_out; got = 1'b1; sif.start = 1'b0;
         end else if (noise) begin
            sif.start = 1'($urandom); sif.op = 3'($urandom);
            sif.n = 5'($urandom); sif.data_in = $urandom;
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_ignored(input logic [2:0] o);
      @(negedge clk);
      sif.start = 1'b1; sif.op = o; sif.n = 5'($urandom); sif.data_in = $urandom;
      @(negedge clk);
      sif.start = 1'b0;
   endtask

   logic [31:0] res;
   int          lat, bc;

   initial begin
      sif.start = 1'b0; sif.op = 3'b000; sif.n = '0; sif.data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, sif.busy}, 32'd0);
      chk("rst_done", {31'd0, sif.done}, 32'd0);
      chk("rst_data", sif.data_out, 32'd0);
      reset = 1'b1;

      req(3'b001, 5'd7, 32'hDEADBEEF, 1'b0, res, lat, bc);
      chk("load_data", res, 32'hDEADBEEF);
      chk("load_lat", lat, 32'd1);

      req(3'b010, 5'd4, 32'h0000000F, 1'b0, res, lat, bc);
      chk("sll4_data", res, 32'h000000F0);
      chk("sll4_lat", lat, 32'd5);
      chk("sll4_busy", bc, 32'd5);

      req(3'b100, 5'd16, 32'h80001234, 1'b0, res, lat, bc);
      chk("sra16_data", res, 32'hFFFF8000);
      req(3'b011, 5'd16, 32'h80001234, 1'b0, res, lat, bc);
      chk("srl16_data", res, 32'h00008000);

      req(3'b101, 5'd31, 32'h00000001, 1'b0, res, lat, bc);
      chk("ror31_data", res, 32'h00000002);
      chk("ror31_lat", lat, 32'd32);
      req(3'b010, 5'd0, 32'h00000005, 1'b0, res, lat, bc);
      chk("sll0_data", res, 32'h00000005);
      chk("sll0_lat", lat, 32'd1);

      req(3'b010, 5'd10, 32'h00000003, 1'b1, res, lat, bc);
      chk("noise_sll10", res, 32'h00000C00);
      pulse_ignored(3'b000);
      pulse_ignored(3'b111);
      @(negedge clk);
      chk("nop_busy", {31'd0, sif.busy}, 32'd0);
      chk("nop_data", sif.data_out, 32'h00000C00);

      @(negedge clk);
      sif.start = 1'b1; sif.op = 3'b010; sif.n = 5'd10; sif.data_in = 32'h1;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_data", sif.data_out, 32'd0);
      chk("abort_busy", {31'd0, sif.busy}, 32'd0);
      chk("abort_done", {31'd0, sif.done}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req(3'b110, 5'd4, 32'h80000001, 1'b0, res, lat, bc);
      chk("after_rst_rol4", res, 32'h00000018);

      for (int t = 0; t < 60; t++) begin
         logic [2:0]  o;
         logic [4:0]  nn;
         logic [31:0] d;
         o = 3'($urandom_range(0, 7));
         nn = 5'($urandom_range(0, 31));
         d = $urandom;
         if (o == 3'b000 || o == 3'b111) pulse_ignored(o);
         else begin
            req(o, nn, d, 1'($urandom), res, lat, bc);
            chk("rand_result", res, f(d, o, (o == 3'b001) ? 0 : int'(nn)));
         end
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
